// File: rtl/ex_pkg.sv
// Shared constants for the execute stage.
// Opcodes, control-word fields, flag indices, FSM states.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_ADDR = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hB;

  localparam int CTRL_OP_LSB = 0;
  localparam int CTRL_OP_MSB = 3;
  localparam int CTRL_DST_LSB = 4;
  localparam int CTRL_DST_MSB = 7;
  localparam int CTRL_REGWR = 8;
  localparam int CTRL_MEMRD = 9;
  localparam int CTRL_MEMWR = 10;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } ex_state_t;

  function automatic logic is_md_op(
    input logic [3:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// Sequential unsigned MUL/DIV, one step per cycle.
// Shift-add multiply, restoring divide, shared accumulator.
module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int W    = 16,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         div0
);

  localparam int CW = $clog2(ITER + 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   opnd;
  logic [CW-1:0]  cnt;
  logic           act;
  logic           is_div;
  logic           div0_q;

  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic [W:0]     rem_df;
  logic           ge;

  // One multiply or divide step on the accumulator
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]};
    if (acc[0]) mul_sum = mul_sum + {1'b0, opnd};
    rem_sh = acc[2*W-1:W-1];
    ge = rem_sh >= {1'b0, opnd};
    rem_df = ge ? rem_sh - {1'b0, opnd} : rem_sh;
    if (is_div)
      acc_nxt = {rem_df[W-1:0], acc[W-2:0], ge};
    else
      acc_nxt = {mul_sum, acc[W-1:1]};
  end

  // Operand latch, iteration counter and accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      opnd <= '0;
      cnt <= '0;
      act <= 1'b0;
      is_div <= 1'b0;
      div0_q <= 1'b0;
    end else if (kill) begin
      cnt <= '0;
      act <= 1'b0;
    end else if (start) begin
      is_div <= (op == OP_DIV);
      div0_q <= (op == OP_DIV) && (b == '0);
      opnd <= (op == OP_DIV) ? b : a;
      acc <= {{W{1'b0}}, (op == OP_DIV) ? a : b};
      cnt <= '0;
      act <= 1'b1;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
    end
  end

  assign busy = act && (cnt != CW'(ITER));
  assign done = act && (cnt == CW'(ITER));
  assign lo = acc[W-1:0];
  assign hi = acc[2*W-1:W];
  assign div0 = div0_q;

endmodule

// File: rtl/ex_stage_alu_muldiv.sv
// Execute stage: single-cycle ALU plus sequential MUL/DIV.
// Results land in the EX/MEM register behind a valid/ready handshake.
module ex_stage_alu_muldiv
  import ex_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CTRL_W  = 16,
  parameter int MD_ITER = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_r15,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_result15,
  output logic              out_wr15,
  output logic [DATA_W-1:0] out_store,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [3:0]        out_flags,
  output logic              out_div0
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  ex_state_t state;
  ex_state_t nxt;

  logic [3:0]        op;
  logic              room;
  logic              accept;
  logic              start;
  logic              load_alu;
  logic              load_md;

  logic              md_busy;
  logic              md_done;
  logic              md_div0;
  logic [DATA_W-1:0] md_lo;
  logic [DATA_W-1:0] md_hi;
  logic [CTRL_W-1:0] md_ctrl;
  logic [DATA_W-1:0] md_store;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        alu_flags;

  assign op = in_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
  assign room = !out_valid || out_ready;
  assign in_ready = (state == S_IDLE) && room && !flush;
  assign accept = in_valid && in_ready;

  ex_muldiv_seq #(
    .W    (DATA_W),
    .ITER (MD_ITER)
  ) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .kill  (flush),
    .op    (op),
    .a     (in_a),
    .b     (in_b),
    .busy  (md_busy),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi),
    .div0  (md_div0)
  );

  // Single-cycle ALU result and flags
  always_comb begin
    sum = {1'b0, in_a} + {1'b0, in_b};
    dif = {1'b0, in_a} - {1'b0, in_b};
    sh = in_b[SH_W-1:0];
    alu_res = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum[MSB:0];
        alu_c = sum[DATA_W];
        alu_v = (in_a[MSB] == in_b[MSB]) &&
                (sum[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        alu_res = dif[MSB:0];
        alu_c = !dif[DATA_W];
        alu_v = (in_a[MSB] != in_b[MSB]) &&
                (dif[MSB] != in_a[MSB]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << sh;
      OP_SRL:  alu_res = in_a >> sh;
      OP_SRA:  alu_res = $signed(in_a) >>> sh;
      OP_ADDR: alu_res = in_r15 + in_a;
      OP_PASS: alu_res = in_b;
      default: alu_res = '0;
    endcase
    alu_flags = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Next state, MUL/DIV launch and output-register load strobes
  always_comb begin
    nxt = state;
    start = 1'b0;
    load_alu = 1'b0;
    load_md = 1'b0;
    if (flush) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_md_op(op)) begin
              start = 1'b1;
              nxt = S_BUSY;
            end else begin
              load_alu = 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (md_done) begin
            if (room) begin
              load_md = 1'b1;
              nxt = S_IDLE;
            end else begin
              nxt = S_DONE;
            end
          end else if (!md_busy) begin
            nxt = S_IDLE;
          end
        end
        S_DONE: begin
          if (room) begin
            load_md = 1'b1;
            nxt = S_IDLE;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Side data of the in-flight MUL/DIV
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_ctrl <= '0;
      md_store <= '0;
    end else if (start) begin
      md_ctrl <= in_ctrl;
      md_store <= in_b;
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_result15 <= '0;
      out_wr15 <= 1'b0;
      out_store <= '0;
      out_ctrl <= '0;
      out_flags <= '0;
      out_div0 <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      out_result <= alu_res;
      out_result15 <= '0;
      out_wr15 <= 1'b0;
      out_store <= in_b;
      out_ctrl <= in_ctrl;
      out_flags <= alu_flags;
      out_div0 <= 1'b0;
    end else if (load_md) begin
      out_valid <= 1'b1;
      out_result <= md_lo;
      out_result15 <= md_hi;
      out_wr15 <= 1'b1;
      out_store <= md_store;
      out_ctrl <= md_ctrl;
      out_flags <= '0;
      out_div0 <= md_div0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
